// File: rtl/node_router_link.sv
// node_router_link: node-side byte-link endpoint that serialises 32-bit packets to a router
// and reassembles inbound bytes into packets, with a packet FIFO in each direction.
module node_router_link #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      tx_valid,
  input  logic [31:0]               tx_packet,
  output logic                      tx_ready,
  output logic                      rx_valid,
  output logic [31:0]               rx_packet,
  input  logic                      rx_ready,
  input  logic                      to_router_free,
  output logic                      to_router_put,
  output logic [7:0]                to_router_payload,
  input  logic                      from_router_put,
  input  logic [7:0]                from_router_payload,
  output logic                      from_router_free,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      protocol_error
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL = (TAW + 1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL = (RAW + 1)'(RX_DEPTH);

  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, SEND3, GAP} tx_state_t;

  tx_state_t      tx_state, tx_next;
  logic [31:0]    tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [23:0]    tx_shift;
  logic           tx_push, tx_pop;

  assign tx_ready = tx_count < TX_FULL;
  assign tx_push  = tx_valid && tx_ready;

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      IDLE:    if (tx_count != '0 && to_router_free) begin
                 tx_next = SEND0;
                 tx_pop  = 1'b1;
               end
      SEND0:   tx_next = SEND1;
      SEND1:   tx_next = SEND2;
      SEND2:   tx_next = SEND3;
      SEND3:   tx_next = GAP;
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clock)
    if (tx_push) tx_mem[tx_wr] <= tx_packet;

  // Byte 0 leaves straight from the FIFO head; the rest shift out of tx_shift MSB first.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      tx_state          <= IDLE;
      tx_wr             <= '0;
      tx_rd             <= '0;
      tx_count          <= '0;
      tx_shift          <= '0;
      to_router_put     <= 1'b0;
      to_router_payload <= 8'h00;
    end else begin
      tx_state          <= tx_next;
      tx_wr             <= tx_wr + TAW'(tx_push);
      tx_rd             <= tx_rd + TAW'(tx_pop);
      tx_count          <= tx_count + (TAW + 1)'(tx_push) - (TAW + 1)'(tx_pop);
      tx_shift          <= tx_pop ? tx_mem[tx_rd][23:0] : {tx_shift[15:0], 8'h00};
      to_router_put     <= tx_next inside {SEND0, SEND1, SEND2, SEND3};
      to_router_payload <= tx_pop ? tx_mem[tx_rd][31:24] :
                           (tx_next inside {SEND1, SEND2, SEND3}) ? tx_shift[23:16] : 8'h00;
    end

  logic [1:0]     rx_phase, rx_phase_n;
  logic [23:0]    rx_part;
  logic [31:0]    rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [RAW:0]   rx_count_n;
  logic           rx_start, rx_push, rx_pop, rx_viol;

  assign rx_start   = from_router_put && from_router_free && rx_phase == 2'd0;
  assign rx_push    = from_router_put && rx_phase == 2'd3;
  assign rx_pop     = rx_valid && rx_ready;
  assign rx_viol    = rx_phase == 2'd0 ? from_router_put && !from_router_free : !from_router_put;
  assign rx_phase_n = rx_phase == 2'd0 ? {1'b0, rx_start} : from_router_put ? rx_phase + 2'd1 : 2'd0;
  assign rx_count_n = rx_count + (RAW + 1)'(rx_push) - (RAW + 1)'(rx_pop);
  assign rx_valid   = rx_count != '0;
  assign rx_packet  = rx_valid ? rx_mem[rx_rd] : 32'h0;

  always_ff @(posedge clock)
    if (rx_push) rx_mem[rx_wr] <= {rx_part, from_router_payload};

  // Free is only offered between packets and only when a whole slot is guaranteed.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rx_phase         <= 2'd0;
      rx_part          <= '0;
      rx_wr            <= '0;
      rx_rd            <= '0;
      rx_count         <= '0;
      from_router_free <= 1'b0;
      protocol_error   <= 1'b0;
    end else begin
      rx_phase         <= rx_phase_n;
      rx_part          <= from_router_put ? {rx_part[15:0], from_router_payload} : rx_part;
      rx_wr            <= rx_wr + RAW'(rx_push);
      rx_rd            <= rx_rd + RAW'(rx_pop);
      rx_count         <= rx_count_n;
      from_router_free <= rx_phase_n == 2'd0 && rx_count_n < RX_FULL;
      protocol_error   <= protocol_error | rx_viol;
    end
endmodule

// File: tb/tb_node_router_link.sv
// tb_node_router_link: directed and random stimulus checked every cycle against a
// packet-level model of both link directions.
module tb_node_router_link;
  logic        clock = 0, reset_n = 1;
  logic        tx_valid = 0, rx_ready = 0, to_router_free = 0, from_router_put = 0;
  logic [31:0] tx_packet = 0;
  logic [7:0]  from_router_payload = 0;
  logic        tx_ready, rx_valid, to_router_put, from_router_free, protocol_error;
  logic [31:0] rx_packet;
  logic [7:0]  to_router_payload;
  logic [2:0]  tx_count, rx_count;

  int n_chk = 0, n_fail = 0;

  logic [31:0] txq[$], rxq[$], cur, rpkt;
  int          age, rb;
  logic [1:0]  mph;
  logic [23:0] mpart;
  logic        mfree, merr;

  node_router_link #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .tx_valid(tx_valid), .tx_packet(tx_packet), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_packet(rx_packet), .rx_ready(rx_ready),
    .to_router_free(to_router_free), .to_router_put(to_router_put),
    .to_router_payload(to_router_payload),
    .from_router_put(from_router_put), .from_router_payload(from_router_payload),
    .from_router_free(from_router_free),
    .tx_count(tx_count), .rx_count(rx_count), .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    age = 100;
    cur = 0;
    mph = 0;
    mpart = 0;
    mfree = 0;
    merr = 0;
  endtask

  task automatic rst_checks(string tag);
    check({tag, "_put"}, to_router_put, 0);
    check({tag, "_payload"}, to_router_payload, 0);
    check({tag, "_rfree"}, from_router_free, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_packet"}, rx_packet, 0);
    check({tag, "_tx_count"}, tx_count, 0);
    check({tag, "_rx_count"}, rx_count, 0);
    check({tag, "_perr"}, protocol_error, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
  endtask

  // One clock: model consumes the inputs seen at the edge, then every output is compared.
  task automatic tick();
    logic        c_txv = tx_valid, c_free = to_router_free, c_fput = from_router_put, c_rxr = rx_ready;
    logic [31:0] c_pkt = tx_packet;
    logic [7:0]  c_fpay = from_router_payload;
    logic [7:0]  exp_pay;
    logic        push, start;
    @(posedge clock);
    #1;
    if (!reset_n) model_reset();
    else begin
      push  = c_txv && txq.size() < 4;
      start = txq.size() > 0 && c_free && age >= 5;
      if (start) begin
        cur = txq.pop_front();
        age = 0;
      end else if (age < 100) age++;
      if (push) txq.push_back(c_pkt);
      if (c_rxr && rxq.size() > 0) void'(rxq.pop_front());
      if (c_fput && mph == 0) begin
        if (mfree) begin
          mpart = {16'h0, c_fpay};
          mph = 1;
        end else merr = 1;
      end else if (c_fput) begin
        if (mph == 3) begin
          rxq.push_back({mpart, c_fpay});
          mph = 0;
        end else begin
          mpart = {mpart[15:0], c_fpay};
          mph++;
        end
      end else if (mph != 0) begin
        merr = 1;
        mph = 0;
      end
      mfree = mph == 0 && rxq.size() < 4;
    end
    exp_pay = 0;
    if (age <= 3) exp_pay = cur[31 - 8 * age -: 8];
    check("tx_put", to_router_put, age <= 3);
    check("tx_payload", to_router_payload, exp_pay);
    check("tx_count", tx_count, txq.size());
    check("tx_ready", tx_ready, txq.size() < 4);
    check("rx_free", from_router_free, mfree);
    check("rx_count", rx_count, rxq.size());
    check("rx_valid", rx_valid, rxq.size() > 0);
    check("rx_packet", rx_packet, rxq.size() > 0 ? rxq[0] : 32'h0);
    check("perr", protocol_error, merr);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_rx(logic [31:0] p, int n);
    int w = 0;
    while (!from_router_free && w < 40) begin
      tick();
      w++;
    end
    if (!from_router_free) check("rx_free_wait", from_router_free, 1);
    for (int i = 0; i < n; i++) begin
      from_router_put = 1;
      from_router_payload = p[31 - 8 * i -: 8];
      tick();
    end
    from_router_put = 0;
    from_router_payload = 0;
  endtask

  initial begin
    model_reset();
    #1 reset_n = 0;
    #1 rst_checks("rst");
    run(2);
    @(negedge clock) reset_n = 1;
    run(2);
    // single outbound packet
    tx_valid = 1; tx_packet = 32'hA1B2C3D4; to_router_free = 1;
    tick();
    tx_valid = 0;
    run(8);
    // fill TX FIFO while the router is busy, then release it
    to_router_free = 0;
    for (int i = 1; i <= 4; i++) begin
      tx_valid = 1;
      tx_packet = i;
      tick();
    end
    tx_valid = 0;
    check("tx_full_ready", tx_ready, 0);
    check("tx_full_count", tx_count, 4);
    run(3);
    to_router_free = 1;
    run(30);
    // single inbound packet
    send_rx(32'h12345678, 4);
    check("rx_first", rx_packet, 32'h12345678);
    check("rx_free_back", from_router_free, 1);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    // fill RX FIFO, then pop one
    for (int i = 0; i < 4; i++) send_rx(32'hA0000000 | i, 4);
    check("rx_full_count", rx_count, 4);
    check("rx_full_free", from_router_free, 0);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    check("rx_free_after_pop", from_router_free, 1);
    check("rx_order", rx_packet, 32'hA0000001);
    rx_ready = 1;
    run(4);
    rx_ready = 0;
    // truncated inbound packet, then a clean one
    send_rx(32'hDEADBEEF, 2);
    tick();
    check("perr_set", protocol_error, 1);
    check("perr_no_push", rx_count, 0);
    send_rx(32'hCAFEF00D, 4);
    check("rx_after_err", rx_packet, 32'hCAFEF00D);
    check("perr_sticky", protocol_error, 1);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    // reset during SEND1 with an inbound packet half received
    tx_valid = 1; tx_packet = 32'h55667788;
    tick();
    tx_valid = 0;
    tick();
    from_router_put = 1; from_router_payload = 8'h11;
    tick();
    from_router_payload = 8'h22;
    #3 reset_n = 0;
    #1 rst_checks("midrst");
    from_router_put = 0; from_router_payload = 0;
    run(2);
    @(negedge clock) reset_n = 1;
    run(2);
    tx_valid = 1; tx_packet = 32'h0BADC0DE;
    tick();
    tx_valid = 0;
    send_rx(32'h87654321, 4);
    check("rx_after_rst", rx_packet, 32'h87654321);
    run(8);
    rx_ready = 1;
    tick();
    // randomized traffic on both directions
    rb = 0;
    for (int c = 0; c < 3000; c++) begin
      tx_valid = $urandom % 2;
      tx_packet = $urandom;
      to_router_free = ($urandom % 4) != 0;
      rx_ready = $urandom % 2;
      if (rb == 0) begin
        if (from_router_free && ($urandom % 2) == 1) begin
          rpkt = $urandom;
          from_router_put = 1;
          from_router_payload = rpkt[31:24];
          rb = 1;
        end else begin
          from_router_put = !from_router_free && ($urandom % 32) == 0;
          from_router_payload = from_router_put ? 8'($urandom) : 8'h00;
        end
      end else if (($urandom % 64) == 0) begin
        from_router_put = 0;
        from_router_payload = 0;
        rb = 0;
      end else begin
        from_router_put = 1;
        from_router_payload = rpkt[31 - 8 * rb -: 8];
        rb = (rb + 1) % 4;
      end
      tick();
    end
    tx_valid = 0; to_router_free = 1; rx_ready = 1;
    from_router_put = 0; from_router_payload = 0;
    run(40);
    check("tx_drained", tx_count, 0);
    check("rx_drained", rx_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/node_router_link.md
Name: node_router_link

Overview:
- Node-side endpoint of the router byte-link protocol, the counterpart to a router port. Serialises 32-bit packets from local node logic into four 8-bit transfers toward a router input port.
- Deserialises four 8-bit transfers from a router output port back into 32-bit packets.
- Each direction has a small packet FIFO so node logic and link timing are decoupled. One instance per node.

Parameters:
- TX_DEPTH, 4: transmit FIFO depth in 32-bit packets (power of 2, ≥2).
- RX_DEPTH, 4: receive FIFO depth in 32-bit packets (power of 2, ≥2).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  local packet offered.
- tx_packet  in  32  local packet to send.
- tx_ready  out  1  TX FIFO can accept; a transfer occurs when tx_valid&tx_ready.
- rx_valid  out  1  RX FIFO head valid.
- rx_packet  out  32  RX FIFO head packet.
- rx_ready  in  1  local logic pops head when rx_valid&rx_ready.
- to_router_free  in  1  router input port free to accept a packet.
- to_router_put  out  1  node driving a byte to router this cycle.
- to_router_payload  out  8  byte to router.
- from_router_put  in  1  router driving a byte to node this cycle.
- from_router_payload  in  8  byte from router.
- from_router_free  out  1  node can accept a full packet from router.
- tx_count  out  $clog2(TX_DEPTH)+1  packets held in TX FIFO.
- rx_count  out  $clog2(RX_DEPTH)+1  packets held in RX FIFO.
- protocol_error  out  1  sticky; set on any inbound link violation.

Behaviour:

Byte order and reset:
- Byte order on both links is MSB first: [31:24], [23:16], [15:8], [7:0].
- Reset (async assert, sync release) values: to_router_put=0, to_router_payload=0, from_router_free=0, rx_valid=0, rx_packet=0, tx_count=0, rx_count=0, protocol_error=0.
- Both FIFOs are emptied and both FSMs return to idle. A reset mid-packet abandons the packet; no partial state survives.
- tx_ready = (tx_count < TX_DEPTH), combinational from registered count. It is 1 immediately after reset.

TX FSM (states IDLE, SEND0, SEND1, SEND2, SEND3, GAP):
- IDLE: if tx_count>0 and to_router_free=1, pop the FIFO head into a shift register and go to SEND0. Otherwise stay in IDLE.
- SENDn: to_router_put=1 and to_router_payload = byte n, then advance to the next state. SEND3 goes to GAP.
- put is held high for exactly 4 consecutive cycles. to_router_free is ignored outside IDLE.
- GAP: put=0 for one cycle, then IDLE. This lets the router's free deassert before it is resampled.
- put and payload are registered outputs. payload is 0 whenever put=0.
- Latency: packet accepted at edge k gives put high first in cycle k+2 when the FIFO was empty and free=1.
- Simultaneous FIFO push and pop is allowed. Count is unchanged in that case; a push when full is impossible because tx_ready=0.

RX path (phase counter 0..3, 24-bit partial register):
- from_router_free is registered: next = (next_phase==0) && (next rx_count < RX_DEPTH).
- from_router_free drops the cycle after byte 0 is received and stays low until the packet completes.
- put=1 with free=1 and phase 0: capture byte 0, phase becomes 1.
- put=1 at phase 1..3: capture the byte. At phase 3, push {partial, byte} into the RX FIFO and set phase to 0.
- Latency: rx_valid is high the cycle after the 4th byte's cycle, when the FIFO was empty.
- Violation A: put=1 while phase 0 and free=0. The byte is dropped and protocol_error is set.
- Violation B: put=0 at phase 1..3. The partial packet is discarded, phase becomes 0, and protocol_error is set.
- protocol_error is cleared only by reset.
- RX FIFO push and pop in the same cycle is allowed. rx_packet shows the head and is 0 when empty.
- An RX overflow cannot occur: free guarantees one slot for every packet started.

Test Plan:
- Reset, tx_valid with 0xA1B2C3D4, to_router_free=1:
  - put high 4 cycles starting 2 cycles after acceptance, payload A1,B2,C3,D4.
  - put then low for ≥1 GAP cycle; tx_count returns 0.
- Push 4 packets (1..4) with to_router_free=0:
  - tx_ready=0 at count 4 and no put.
  - Raise free: packets sent in order, each followed by a GAP, and tx_ready rises after the first pop.
- Router sends 12,34,56,78 with put for 4 cycles:
  - from_router_free drops after byte 0.
  - rx_valid=1 with rx_packet=0x12345678 the next cycle; free returns to 1.
- rx_ready=0 while 4 packets arrive:
  - rx_count=4 and from_router_free=0.
  - Pop one: free returns to 1 the following cycle, and the FIFO order is preserved.
- Router put drops after 2 bytes:
  - protocol_error=1 and no push.
  - The next full packet 0xCAFEF00D is received correctly; protocol_error stays 1.
- reset_n asserted during SEND1 and mid-RX:
  - All outputs go to reset values immediately and FIFOs are empty.
  - A clean packet after release is sent and received normally.
